// File: rtl/packed_fifo_read_sched.sv
// Read-side scheduler for a multi-queue packed FIFO: round-robin pop of queue
// heads with a mandatory idle cycle after each pop, feeding a valid/ready output.
module packed_fifo_read_sched #(
   parameter int logN  = 2,
   parameter int WIDTH = 36,
   parameter int CNT_W = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [(1<<logN)-1:0]          q_enable,
   input  logic [(1<<logN)-1:0]          fifo_has_data,
   input  logic [(1<<logN)*WIDTH-1:0]    fifo_data,
   output logic                          fifo_read,
   output logic [logN-1:0]               fifo_rid,
   output logic                          out_valid,
   output logic [WIDTH-1:0]              out_data,
   output logic [logN-1:0]               out_qid,
   input  logic                          out_ready,
   output logic [CNT_W-1:0]              stall_count
);
   localparam int N = 1 << logN;

   typedef enum logic {ARB, GAP} state_t;

   state_t            r_state, w_state_nxt;
   logic [logN-1:0]   r_rr_last;
   logic              r_out_valid;
   logic [WIDTH-1:0]  r_out_data;
   logic [logN-1:0]   r_out_qid;
   logic [CNT_W-1:0]  r_stall;

   logic [N-1:0]      w_cand;
   logic              w_any, w_slot_free, w_grant;
   logic [logN-1:0]   w_gnt;

   assign w_cand      = fifo_has_data & q_enable;
   assign w_any       = |w_cand;
   assign w_slot_free = ~r_out_valid | out_ready;

   // Descending scan, last hit wins: the nearest candidate after rr_last is chosen.
   always_comb begin
      w_gnt = r_rr_last;
      for (int k = N; k >= 1; k--)
         if (w_cand[r_rr_last + logN'(k)]) w_gnt = r_rr_last + logN'(k);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      case (r_state)
         ARB: if (w_any && w_slot_free && !reset) begin
            w_grant     = 1'b1;
            w_state_nxt = GAP;
         end
         GAP: w_state_nxt = ARB;
         default: w_state_nxt = ARB;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= ARB;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rr_last   <= logN'(N - 1);
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_qid   <= '0;
      end else if (w_grant) begin
         r_rr_last   <= w_gnt;
         r_out_valid <= 1'b1;
         r_out_data  <= fifo_data[w_gnt*WIDTH +: WIDTH];
         r_out_qid   <= w_gnt;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Counts ARB cycles where work exists but the output slot is occupied.
   always_ff @(posedge clock) begin
      if (reset)
         r_stall <= '0;
      else if (r_state == ARB && w_any && !w_slot_free && !(&r_stall))
         r_stall <= r_stall + 1'b1;
   end

   assign fifo_read   = w_grant;
   assign fifo_rid    = w_grant ? w_gnt : r_rr_last;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_qid     = r_out_qid;
   assign stall_count = r_stall;
endmodule

// File: tb/tb_packed_fifo_read_sched.sv
// Bench for packed_fifo_read_sched: directed scenarios plus random traffic,
// checked every cycle against a cycle-count based behavioural model.
module tb_packed_fifo_read_sched;
   localparam int LOGN = 2;
   localparam int N    = 4;
   localparam int W    = 36;
   localparam int CW   = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    en, has;
   logic [N*W-1:0]  fd;
   logic            rdy;
   logic            fifo_read;
   logic [LOGN-1:0] fifo_rid;
   logic            out_valid;
   logic [W-1:0]    out_data;
   logic [LOGN-1:0] out_qid;
   logic [CW-1:0]   stall_count;

   always #5 clk = ~clk;

   packed_fifo_read_sched #(.logN(LOGN), .WIDTH(W), .CNT_W(CW)) dut (
      .clock(clk), .reset(rst), .q_enable(en), .fifo_has_data(has),
      .fifo_data(fd), .fifo_read(fifo_read), .fifo_rid(fifo_rid),
      .out_valid(out_valid), .out_data(out_data), .out_qid(out_qid),
      .out_ready(rdy), .stall_count(stall_count));

   int n_chk = 0, n_pass = 0;

   // model state
   bit       m_valid;
   bit [W-1:0] m_data;
   int       m_qid, m_rr, m_since, m_stall;
   bit       obs_read;
   int       obs_rid;
   int       gq[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   function automatic int pick(input logic [N-1:0] c, input int rr);
      for (int k = 1; k <= N; k++) if (c[(rr + k) % N]) return (rr + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_data = '0; m_qid = 0; m_rr = N - 1; m_since = 2; m_stall = 0;
   endtask

   // One clock: compare at the negedge, advance the model, return just after posedge.
   task automatic cyc();
      logic [N-1:0] c;
      bit free, arb, g_ok;
      int g;
      @(negedge clk);
      c    = has & en;
      free = !m_valid || rdy;
      arb  = (m_since >= 2);
      g    = pick(c, m_rr);
      g_ok = !rst && arb && (c != 0) && free;
      chk("fifo_read", 64'(fifo_read), 64'(g_ok));
      chk("fifo_rid", 64'(fifo_rid), g_ok ? 64'(g) : 64'(m_rr));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
         chk("out_data", 64'(out_data), 64'(m_data));
         chk("out_qid", 64'(out_qid), 64'(m_qid));
      end
      chk("stall_count", 64'(stall_count), 64'(m_stall));
      obs_read = fifo_read;
      obs_rid  = int'(fifo_rid);
      if (fifo_read) gq.push_back(obs_rid);
      if (rst) model_reset();
      else begin
         if (arb && (c != 0) && !free && m_stall < (1 << CW) - 1) m_stall++;
         if (g_ok) begin
            m_valid = 1; m_data = fd[g*W +: W]; m_qid = g; m_rr = g; m_since = 1;
         end else begin
            if (m_valid && rdy) m_valid = 0;
            if (m_since < 2) m_since++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1; cyc(); rst = 0;
   endtask

   initial begin
      int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      model_reset();
      rst = 1; en = '1; has = '0; rdy = 1; fd = '0;
      m_valid = 1'bx ? 0 : 0;
      @(posedge clk); #1;
      cyc(); cyc();
      rst = 0;
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_stall", 64'(stall_count), 64'(0));

      // two sparse queues
      has = 4'b0101;
      fd[0*W +: W] = 36'h0000000A0; fd[1*W +: W] = 36'h0000000B1;
      fd[2*W +: W] = 36'h0000000C2; fd[3*W +: W] = 36'h0000000D3;
      cyc();
      chk("t0_read", 64'(obs_read), 64'(1)); chk("t0_rid", 64'(obs_rid), 64'(0));
      chk("t1_data", 64'(out_data), 64'h0A0); chk("t1_qid", 64'(out_qid), 64'(0));
      cyc();
      chk("t1_idle", 64'(obs_read), 64'(0));
      cyc();
      chk("t2_read", 64'(obs_read), 64'(1)); chk("t2_rid", 64'(obs_rid), 64'(2));
      cyc();
      chk("t3_data", 64'(out_data), 64'h0C2); chk("t3_qid", 64'(out_qid), 64'(2));

      // all queues busy: strict rotation, pop every other cycle
      do_reset();
      has = 4'hF; gq.delete();
      for (int i = 0; i < 16; i++) begin
         cyc();
         chk("alt_read", 64'(obs_read), 64'(i % 2 == 0));
      end
      chk("rot_cnt", 64'(gq.size()), 64'(8));
      for (int i = 0; i < 8 && i < gq.size(); i++) chk("rot_seq", 64'(gq[i]), 64'(exp_seq[i]));

      // backpressure with q1 pending
      do_reset();
      has = 4'b0010; rdy = 0;
      cyc(); cyc();
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("bp_noread", 64'(obs_read), 64'(0));
      end
      chk("bp_stall", 64'(stall_count), 64'(5));
      chk("bp_qid", 64'(out_qid), 64'(1));
      chk("bp_data", 64'(out_data), 64'h0B1);
      rdy = 1; cyc();
      chk("bp_replace", 64'(obs_read), 64'(1));
      chk("bp_valid", 64'(out_valid), 64'(1));

      // masked queue 1, then re-enabled
      do_reset();
      has = 4'hF; en = 4'b1101; gq.delete();
      for (int i = 0; i < 7; i++) cyc();
      chk("mask_cnt", 64'(gq.size()), 64'(4));
      if (gq.size() == 4) begin
         chk("mask_g0", 64'(gq[0]), 64'(0)); chk("mask_g1", 64'(gq[1]), 64'(2));
         chk("mask_g2", 64'(gq[2]), 64'(3)); chk("mask_g3", 64'(gq[3]), 64'(0));
      end
      en = 4'hF; cyc(); cyc();
      chk("unmask_read", 64'(obs_read), 64'(1)); chk("unmask_rid", 64'(obs_rid), 64'(1));

      // reset while in the gap with a word held
      do_reset();
      cyc();
      rst = 1; cyc();
      chk("mrst_noread", 64'(obs_read), 64'(0));
      chk("mrst_valid", 64'(out_valid), 64'(0));
      chk("mrst_stall", 64'(stall_count), 64'(0));
      rst = 0; cyc();
      chk("mrst_first", 64'(obs_rid), 64'(0));

      // saturation
      do_reset();
      rdy = 0; has = 4'b0001;
      for (int i = 0; i < 22; i++) cyc();
      chk("sat", 64'(stall_count), 64'hF);

      // random traffic
      rdy = 1; do_reset();
      for (int i = 0; i < 3000; i++) begin
         has = 4'($urandom); en = 4'($urandom | $urandom);
         rdy = ($urandom_range(3, 0) != 0);
         for (int q = 0; q < N; q++) fd[q*W +: W] = {4'($urandom), $urandom};
         rst = ($urandom_range(199, 0) == 0);
         cyc();
      end
      rst = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
